// File: rtl/frac_sad_grid_search.sv
// ---------------------------------------------------------------------------
// frac_sad_grid_search
//
// Accumulates per-candidate line SADs over a block of BLK_H lines, then scans
// the GRID_W x GRID_H candidate grid one candidate per cycle for the minimum.
// The winning motion vector and its accumulated SAD are held on a
// valid/ready output until the consumer takes them.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high
//   in_valid   in   line_sad beat valid
//   in_ready   out  block can accept a beat (IDLE/ACC only)
//   line_sad   in   NCAND*LINE_SAD_W; candidate k=y*GRID_W+x at
//                   bits [k*LINE_SAD_W +: LINE_SAD_W]
//   out_valid  out  result valid (RSLT)
//   out_ready  in   consumer takes result
//   best_sad   out  SAD_W accumulated SAD of the winner
//   best_mvx   out  XW winner column
//   best_mvy   out  YW winner row
//   lambda     in   4-bit MV cost weight (only when MV_COST_EN is defined)
//
// Optional feature macro: MV_COST_EN
//   When defined, the search key becomes
//   sad + lambda*(|x-GRID_W/2| + |y-GRID_H/2|) in SAD_W+8 bits; best_sad
//   still reports the raw SAD of the winner.
// ---------------------------------------------------------------------------
module frac_sad_grid_search #(
    parameter int GRID_W     = 5,
    parameter int GRID_H     = 5,
    parameter int LINE_SAD_W = 12,
    parameter int BLK_H      = 8,
    localparam int NCAND     = GRID_W * GRID_H,
    localparam int SAD_W     = LINE_SAD_W + $clog2(BLK_H),
    localparam int XW        = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int YW        = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NCAND*LINE_SAD_W-1:0] line_sad,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SAD_W-1:0]            best_sad,
    output logic [XW-1:0]               best_mvx,
    output logic [YW-1:0]               best_mvy
`ifdef MV_COST_EN
    ,
    input  logic [3:0]                  lambda
`endif
);

    localparam int IW = (NCAND > 1) ? $clog2(NCAND) : 1;
    localparam int CW = $clog2(BLK_H + 1);
`ifdef MV_COST_EN
    localparam int KW = SAD_W + 8;
`else
    localparam int KW = SAD_W;
`endif

    localparam logic [CW-1:0] LAST_CNT = CW'(BLK_H - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCAND - 1);
    localparam logic [XW-1:0] LAST_COL = XW'(GRID_W - 1);

    typedef enum logic [1:0] {IDLE, ACC, SRCH, RSLT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [SAD_W-1:0]  r_acc [NCAND];
    logic [CW-1:0]     r_cnt;

    // Search cursor: column/row counters track idx so no divider is needed.
    logic [IW-1:0]     r_idx;
    logic [XW-1:0]     r_col;
    logic [YW-1:0]     r_row;

    // Running best during the scan; published to best_* only at the end.
    logic [SAD_W-1:0]  r_cur_sad;
    logic [KW-1:0]     r_cur_key;
    logic [XW-1:0]     r_cur_x;
    logic [YW-1:0]     r_cur_y;

    logic [SAD_W-1:0]  r_best_sad;
    logic [XW-1:0]     r_best_mvx;
    logic [YW-1:0]     r_best_mvy;

    logic              w_accept;
    logic [SAD_W-1:0]  w_cand;
    logic [KW-1:0]     w_key;
    logic              w_take;

`ifdef MV_COST_EN
    // Manhattan distance of (x,y) from the grid centre.
    function automatic logic [7:0] mv_dist(input logic [XW-1:0] x,
                                           input logic [YW-1:0] y);
        logic [7:0] xv, yv, cx, cy, dx, dy;
        xv = 8'(x);
        yv = 8'(y);
        cx = 8'(GRID_W / 2);
        cy = 8'(GRID_H / 2);
        dx = (xv >= cx) ? (xv - cx) : (cx - xv);
        dy = (yv >= cy) ? (yv - cy) : (cy - yv);
        return dx + dy;
    endfunction
`endif

    assign w_accept = in_valid && in_ready;
    assign w_cand   = r_acc[r_idx];

`ifdef MV_COST_EN
    assign w_key = KW'(w_cand) + KW'(lambda) * KW'(mv_dist(r_col, r_row));
`else
    assign w_key = w_cand;
`endif

    // idx 0 always seeds the best; later candidates need strictly lower key,
    // so ties keep the lowest index.
    assign w_take = (r_idx == '0) || (w_key < r_cur_key);

    assign best_sad = r_best_sad;
    assign best_mvx = r_best_mvx;
    assign best_mvy = r_best_mvy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = (BLK_H == 1) ? SRCH : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (w_accept && (r_cnt == LAST_CNT)) begin
                    w_state_nxt = SRCH;
                end
            end
            SRCH: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = RSLT;
                end
            end
            RSLT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCAND; k++) begin
                r_acc[k] <= '0;
            end
            r_cnt      <= '0;
            r_idx      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_cur_sad  <= '0;
            r_cur_key  <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_best_sad <= '0;
            r_best_mvx <= '0;
            r_best_mvy <= '0;
        end else begin
            case (r_state)
                // ---- accumulate: first beat loads, later beats add ----
                IDLE: begin
                    if (w_accept) begin
                        for (int k = 0; k < NCAND; k++) begin
                            r_acc[k] <= SAD_W'(line_sad[k*LINE_SAD_W +: LINE_SAD_W]);
                        end
                        r_cnt <= CW'(1);
                        r_idx <= '0;
                        r_col <= '0;
                        r_row <= '0;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        for (int k = 0; k < NCAND; k++) begin
                            r_acc[k] <= r_acc[k] + SAD_W'(line_sad[k*LINE_SAD_W +: LINE_SAD_W]);
                        end
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                // ---- search: one candidate per cycle ----
                SRCH: begin
                    if (w_take) begin
                        r_cur_sad <= w_cand;
                        r_cur_key <= w_key;
                        r_cur_x   <= r_col;
                        r_cur_y   <= r_row;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_best_sad <= w_take ? w_cand : r_cur_sad;
                        r_best_mvx <= w_take ? r_col  : r_cur_x;
                        r_best_mvy <= w_take ? r_row  : r_cur_y;
                        r_idx      <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + YW'(1);
                        end else begin
                            r_col <= r_col + XW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frac_sad_grid_search.sv
module tb_frac_sad_grid_search;

    localparam int GW  = 5;
    localparam int GH  = 5;
    localparam int LSW = 12;
    localparam int BH  = 8;
    localparam int NC  = GW * GH;
    localparam int SW  = LSW + $clog2(BH);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NC*LSW-1:0] line_sad;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     best_sad;
    logic [2:0]        best_mvx;
    logic [2:0]        best_mvy;
`ifdef MV_COST_EN
    logic [3:0]        lambda;
`endif

    frac_sad_grid_search #(
        .GRID_W(GW), .GRID_H(GH), .LINE_SAD_W(LSW), .BLK_H(BH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .line_sad(line_sad),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .best_sad(best_sad),
        .best_mvx(best_mvx),
        .best_mvy(best_mvy)
`ifdef MV_COST_EN
        ,
        .lambda(lambda)
`endif
    );

    always #5 clk = ~clk;

    // One block: every candidate's per-line SAD is base, except k1/k2.
    typedef struct {
        int base; int k1; int v1; int k2; int v2;
        int ex;   int ey; int esad;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[6];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NC*LSW-1:0] mk(input vec_t v);
        logic [NC*LSW-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) begin
            int val;
            val = (k == v.k1) ? v.v1 : (k == v.k2) ? v.v2 : v.base;
            r[k*LSW +: LSW] = LSW'(val);
        end
        return r;
    endfunction

    task automatic send_beat(input logic [NC*LSW-1:0] d);
        int w;
        w = 0;
        in_valid = 1'b1;
        line_sad = d;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, need 1", w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Sends one block (optional gap before beat gap_at, optional in_valid
    // poke during the search), then checks latency, result, optional
    // backpressure hold, and the return to IDLE after the handshake.
    task automatic run_block(input vec_t v, input int gap_at, input int gap_len,
                             input bit poke, input int bp);
        int n;
        vec_t e;
        logic [SW-1:0] s_sad;
        logic [2:0] s_x, s_y;
        out_ready = 1'b0;
        for (int b = 0; b < BH; b++) begin
            if (b == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk); #1;
                end
            end
            send_beat(mk(v));
        end
        exp_q.push_back(v);
        n = 0;
        while (!out_valid && n < 200) begin
            if (poke && n < 3) begin
                in_valid = 1'b1;
                line_sad = '1;
                if (n == 0) chk("srch_in_ready", in_ready, 0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, NC);
        e = exp_q.pop_front();
        chk("best_mvx", best_mvx, e.ex);
        chk("best_mvy", best_mvy, e.ey);
        chk("best_sad", best_sad, e.esad);
        chk("rslt_in_ready", in_ready, 0);
        s_sad = best_sad;
        s_x   = best_mvx;
        s_y   = best_mvy;
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            chk("bp_hold", (out_valid && best_sad == s_sad && best_mvx == s_x
                            && best_mvy == s_y) ? 1 : 0, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_out_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb, vc, vab, vfr;
        //          base  k1  v1    k2  v2    ex ey esad
        tbl[0] = '{100,  12, 40,   -1, 0,    2, 2, 320};
        tbl[1] = '{50,   3,  10,   17, 10,   3, 0, 80};
        tbl[2] = '{200,  24, 199,  -1, 0,    4, 4, 1592};
        tbl[3] = '{7,    -1, 0,    -1, 0,    0, 0, 56};
        tbl[4] = '{4095, 7,  0,    -1, 0,    2, 1, 0};
        tbl[5] = '{4095, 20, 4094, -1, 0,    0, 4, 32752};
        va = tbl[0];
        vb = tbl[1];
        vc = tbl[2];
        vab = '{1000, 24, 0,  -1, 0, 4, 4, 0};
        vfr = '{300,  0,  5,  -1, 0, 0, 0, 40};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        line_sad  = '0;
`ifdef MV_COST_EN
        lambda    = 4'd0;
`endif
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_best_sad", best_sad, 0);
        chk("rst_best_mvx", best_mvx, 0);
        chk("rst_best_mvy", best_mvy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_block(tbl[i], -1, 0, 1'b0, 0);
        end

        // Gap between beats 4 and 5, plus in_valid held high during search.
        run_block(va, 4, 3, 1'b1, 0);

        // Backpressure, then a new block straight after the handshake.
        run_block(vc, -1, 0, 1'b0, 10);
        run_block(vb, -1, 0, 1'b0, 0);

        // Abort a partial block with reset; the next block must be clean.
        for (int b = 0; b < 5; b++) begin
            send_beat(mk(vab));
        end
        #1;
        reset = 1'b1;
        #2;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_best_sad", best_sad, 0);
        chk("mid_rst_best_mvx", best_mvx, 0);
        chk("mid_rst_best_mvy", best_mvy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_block(vfr, -1, 0, 1'b0, 0);

`ifdef MV_COST_EN
        lambda = 4'd4;
        run_block('{100, 0, 8, 12, 9, 2, 2, 72}, -1, 0, 1'b0, 0);
        lambda = 4'd0;
        run_block('{100, 0, 8, 12, 9, 0, 0, 64}, -1, 0, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
